// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the instruction-fetch slice.
//   DEF_DATA_W / DEF_ADDR_W : default instruction and program-counter widths
//   HALT_OPCODE             : halt-class opcode loaded into ir on reset
//   seq_state_t             : run/halt state of the phase sequencer
package fetch_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_ADDR_W  = 16;
    localparam logic [15:0] HALT_OPCODE = 16'hC000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/fetch_phase_ctr.sv
// fetch_phase_ctr: phase sequencer for the fetch stage.
// It walks phases 1..PHASES per instruction and parks in HALT (phase 0) on request.
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   ack           : instruction memory acknowledge (ends phase 1)
//   stall         : holds the phase in 2..PHASES
//   halt_req      : sampled only in phase PHASES; enters HALT instead of phase 1
//   resume        : leaves HALT
//   phase         : current phase, 0 while halted
//   halted        : sequencer is in HALT
//   fetch_active  : phase 1 while running (drives the memory request)
//   fetch_fire    : fetch completes this cycle (ir/pc_pre load strobe)
//   wb_fire       : write-back completes this cycle (pc load / retire strobe)
module fetch_phase_ctr
    import fetch_pkg::*;
#(
    parameter int unsigned PHASES = 5,
    parameter int unsigned PH_W   = $clog2(PHASES + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ack,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PH_W-1:0] phase,
    output logic            halted,
    output logic            fetch_active,
    output logic            fetch_fire,
    output logic            wb_fire
);

    localparam logic [PH_W-1:0] FIRST = PH_W'(1);
    localparam logic [PH_W-1:0] LAST  = PH_W'(PHASES);

    seq_state_t state;

    always_comb begin
        fetch_active = (state == ST_RUN) && (phase == FIRST);
        fetch_fire   = fetch_active && ack;
        // Phase 1 is never the write-back phase because PHASES >= 2.
        wb_fire      = (state == ST_RUN) && (phase == LAST) && !stall;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_RUN;
            phase  <= FIRST;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (phase == FIRST) begin
                        // stall has no effect while waiting for the fetch
                        if (ack) phase <= FIRST + PH_W'(1);
                    end else if (!stall) begin
                        if (phase == LAST) begin
                            if (halt_req) begin
                                state  <= ST_HALT;
                                phase  <= '0;
                                halted <= 1'b1;
                            end else begin
                                phase <= FIRST;
                            end
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state  <= ST_RUN;
                        phase  <= FIRST;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    phase  <= FIRST;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch stage with its own phase sequencer.
// Owns pc, pc_pre (pc+1 captured at fetch) and ir, drives a req/ack
// instruction-memory port with wait states and broadcasts the phase.
// Optional feature macro: FETCH_SEQ_PERF_EN builds the cycle/instruction
// counters; without it both counter outputs are tied to zero.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   imem_req, imem_addr   : fetch request and address (combinational, addr = pc)
//   imem_ack, imem_rdata  : fetch data valid and instruction word
//   stall                 : freezes phases 2..PHASES
//   branch_taken/_target  : selects next pc at write-back
//   halt_req, resume      : halt after current instruction / leave halt
//   phase, halted         : sequencer status
//   pc, pc_pre, ir        : architectural fetch registers
//   cycle_count           : running (non-halted) cycles
//   instr_count           : retired instructions
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int unsigned        DATA_W   = DEF_DATA_W,
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter int unsigned        PHASES   = 5,
    parameter int unsigned        PH_W     = $clog2(PHASES + 1),
    parameter logic [DATA_W-1:0]  RESET_IR = DATA_W'(HALT_OPCODE),
    parameter int unsigned        CYC_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    input  logic              resume,
    output logic [PH_W-1:0]   phase,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_pre,
    output logic [DATA_W-1:0] ir,
    output logic              halted,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [CYC_W-1:0]  instr_count
);

    logic fetch_active;
    logic fetch_fire;
    logic wb_fire;

    fetch_phase_ctr #(
        .PHASES (PHASES),
        .PH_W   (PH_W)
    ) u_phase_ctr (
        .clock        (clock),
        .reset        (reset),
        .ack          (imem_ack),
        .stall        (stall),
        .halt_req     (halt_req),
        .resume       (resume),
        .phase        (phase),
        .halted       (halted),
        .fetch_active (fetch_active),
        .fetch_fire   (fetch_fire),
        .wb_fire      (wb_fire)
    );

    assign imem_req  = fetch_active;
    assign imem_addr = pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc     <= '0;
            pc_pre <= '0;
            ir     <= RESET_IR;
        end else begin
            if (fetch_fire) begin
                ir     <= imem_rdata;
                pc_pre <= pc + ADDR_W'(1);
            end
            if (wb_fire) begin
                pc <= branch_taken ? branch_target : pc_pre;
            end
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    logic [CYC_W-1:0] cycle_q;
    logic [CYC_W-1:0] instr_q;

    // HALT-entry cycle still counts: halted only rises on the following edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (!halted) cycle_q <= cycle_q + CYC_W'(1);
            if (wb_fire) instr_q <= instr_q + CYC_W'(1);
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed self-checking bench for fetch_seq (PHASES=5, 16-bit).
module tb_fetch_seq;

`ifdef FETCH_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [2:0]  phase;
    logic [15:0] pc;
    logic [15:0] pc_pre;
    logic [15:0] ir;
    logic        halted;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    int errors = 0;
    int checks = 0;

    fetch_seq #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .PHASES   (5),
        .RESET_IR (16'hC000),
        .CYC_W    (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .phase         (phase),
        .pc            (pc),
        .pc_pre        (pc_pre),
        .ir            (ir),
        .halted        (halted),
        .cycle_count   (cycle_count),
        .instr_count   (instr_count)
    );

    always #5 clock = ~clock;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // One full zero-wait instruction starting in phase 1 (5 cycles).
    task automatic do_instr(input logic [15:0] word, input logic br, input logic [15:0] tgt);
        imem_ack = 1'b1; imem_rdata = word;
        step();
        imem_ack = 1'b0;
        step(); step(); step();
        branch_taken = br; branch_target = tgt;
        step();
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        do_reset();
        imem_ack = 1'b0;
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL rst_phase: got %0d expected 1", phase); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h expected 0000", pc); end
        checks++; if (pc_pre !== 16'h0000) begin errors++; $display("FAIL rst_pc_pre: got %h expected 0000", pc_pre); end
        checks++; if (ir !== 16'hC000) begin errors++; $display("FAIL rst_ir: got %h expected c000", ir); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req: got %b expected 1", imem_req); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_cycles: got %0d expected 0", cycle_count); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL rst_instrs: got %0d expected 0", instr_count); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        step();
        imem_ack = 1'b0;
        checks++; if (phase !== 3'd2) begin errors++; $display("FAIL zw_phase2: got %0d expected 2", phase); end
        checks++; if (ir !== 16'h1234) begin errors++; $display("FAIL zw_ir: got %h expected 1234", ir); end
        checks++; if (pc_pre !== 16'h0001) begin errors++; $display("FAIL zw_pc_pre: got %h expected 0001", pc_pre); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_req_off: got %b expected 0", imem_req); end
        step(); step(); step();
        checks++; if (phase !== 3'd5) begin errors++; $display("FAIL zw_phase5: got %0d expected 5", phase); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL zw_pc_hold: got %h expected 0000", pc); end
        step();
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL zw_phase1: got %0d expected 1", phase); end
        checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL zw_addr: got %h expected 0001", imem_addr); end
        checks++; if (cycle_count !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL zw_cycles: got %0d expected %0d", cycle_count, PERF ? 5 : 0); end
        checks++; if (instr_count !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL zw_instrs: got %0d expected %0d", instr_count, PERF ? 1 : 0); end
    endtask

    task automatic test_wait_states();
        do_reset();
        do_instr(16'h1111, 1'b1, 16'h0007);
        checks++; if (imem_addr !== 16'h0007) begin errors++; $display("FAIL ws_addr: got %h expected 0007", imem_addr); end
        imem_ack = 1'b0; imem_rdata = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (phase !== 3'd1) begin errors++; $display("FAIL ws_hold_phase: got %0d expected 1", phase); end
            checks++; if (ir !== 16'h1111) begin errors++; $display("FAIL ws_hold_ir: got %h expected 1111", ir); end
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (ir !== 16'h7777) begin errors++; $display("FAIL ws_ir: got %h expected 7777", ir); end
        checks++; if (pc_pre !== 16'h0008) begin errors++; $display("FAIL ws_pc_pre: got %h expected 0008", pc_pre); end
        step(); step(); step(); step();
        checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL ws_pc: got %h expected 0008", pc); end
        checks++; if (cycle_count !== (PERF ? 32'd13 : 32'd0)) begin errors++; $display("FAIL ws_cycles: got %0d expected %0d", cycle_count, PERF ? 13 : 0); end
        checks++; if (instr_count !== (PERF ? 32'd2 : 32'd0)) begin errors++; $display("FAIL ws_instrs: got %0d expected %0d", instr_count, PERF ? 2 : 0); end
    endtask

    task automatic test_branch_wrap();
        do_reset();
        do_instr(16'h2222, 1'b1, 16'h0040);
        checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL br_addr: got %h expected 0040", imem_addr); end
        do_instr(16'h3333, 1'b1, 16'hFFFF);
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL br_pc_ffff: got %h expected ffff", pc); end
        imem_ack = 1'b1; imem_rdata = 16'h4444;
        step();
        imem_ack = 1'b0;
        checks++; if (pc_pre !== 16'h0000) begin errors++; $display("FAIL wrap_pc_pre: got %h expected 0000", pc_pre); end
        step(); step(); step(); step();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h expected 0000", pc); end
    endtask

    task automatic test_stall();
        do_reset();
        // stall is ignored in phase 1
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h5A5A;
        step();
        stall = 1'b0; imem_ack = 1'b0;
        checks++; if (phase !== 3'd2) begin errors++; $display("FAIL st_ph1_ignored: got %0d expected 2", phase); end
        step();
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL st_enter3: got %0d expected 3", phase); end
        stall = 1'b1;
        step();
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL st_hold_a: got %0d expected 3", phase); end
        step();
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL st_hold_b: got %0d expected 3", phase); end
        stall = 1'b0;
        step();
        checks++; if (phase !== 3'd4) begin errors++; $display("FAIL st_phase4: got %0d expected 4", phase); end
        step();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL st_pc_hold: got %h expected 0000", pc); end
        step();
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL st_pc_new: got %h expected 0001", pc); end
        checks++; if (cycle_count !== (PERF ? 32'd7 : 32'd0)) begin errors++; $display("FAIL st_cycles: got %0d expected %0d", cycle_count, PERF ? 7 : 0); end
    endtask

    task automatic test_halt();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 16'h6666;
        step();
        imem_ack = 1'b0;
        halt_req = 1'b1;  // phase 2: must not be latched
        step();
        halt_req = 1'b0;
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL hl_early_ignored: got %0d expected 3", phase); end
        step(); step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL hl_phase: got %0d expected 0", phase); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hl_halted: got %b expected 1", halted); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hl_req: got %b expected 0", imem_req); end
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL hl_pc: got %h expected 0001", pc); end
        imem_ack = 1'b1; imem_rdata = 16'h9999;
        step(); step();
        imem_ack = 1'b0;
        checks++; if (ir !== 16'h6666) begin errors++; $display("FAIL hl_ir_hold: got %h expected 6666", ir); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hl_stay: got %b expected 1", halted); end
        resume = 1'b1;
        step();
        resume = 1'b0;
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL hl_resume_phase: got %0d expected 1", phase); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hl_resume_halted: got %b expected 0", halted); end
        checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL hl_resume_addr: got %h expected 0001", imem_addr); end
        checks++; if (cycle_count !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL hl_cycles: got %0d expected %0d", cycle_count, PERF ? 5 : 0); end
        resume = 1'b1;  // resume outside HALT has no effect
        imem_ack = 1'b1; imem_rdata = 16'hABCD;
        step();
        resume = 1'b0; imem_ack = 1'b0;
        checks++; if (ir !== 16'hABCD) begin errors++; $display("FAIL hl_refetch_ir: got %h expected abcd", ir); end
        checks++; if (pc_pre !== 16'h0002) begin errors++; $display("FAIL hl_refetch_pre: got %h expected 0002", pc_pre); end
        checks++; if (phase !== 3'd2) begin errors++; $display("FAIL hl_refetch_phase: got %0d expected 2", phase); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        do_instr(16'h1357, 1'b0, 16'h0000);
        step();  // waiting in phase 1, no ack
        checks++; if (pc_pre !== 16'h0001) begin errors++; $display("FAIL rm_pre_setup: got %h expected 0001", pc_pre); end
        imem_ack = 1'b1; imem_rdata = 16'h5555;
        do_reset();
        imem_ack = 1'b0;
        checks++; if (ir !== 16'hC000) begin errors++; $display("FAIL rm_ir: got %h expected c000", ir); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rm_pc: got %h expected 0000", pc); end
        checks++; if (pc_pre !== 16'h0000) begin errors++; $display("FAIL rm_pc_pre: got %h expected 0000", pc_pre); end
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL rm_phase: got %0d expected 1", phase); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL rm_instrs: got %0d expected 0", instr_count); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch_wrap();
        test_stall();
        test_halt();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Parametrised instruction-fetch stage with its own phase sequencer. It owns the program counter, the pre-incremented PC and the instruction register. It also drives a request/acknowledge instruction-memory port with wait states, and broadcasts the current phase to the rest of the datapath. It sits between instruction memory and the decode/execute phases, and replaces the fixed five-phase, zero-wait fetch logic.

## Interface
Parameters:
- DATA_W, 16, instruction/data width
- ADDR_W, 16, program counter width
- PHASES, 5, phases per instruction (min 2); phase 1 = fetch, phase PHASES = PC write-back
- PH_W, $clog2(PHASES+1), width of phase output
- RESET_IR, 16'hC000, instruction register value after reset (halt-class opcode)
- CYC_W, 32, cycle/instruction counter width

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address, equals pc
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  DATA_W  instruction word
- stall  in  1  freezes phase advance in phases 2..PHASES
- branch_taken  in  1  sampled in phase PHASES
- branch_target  in  ADDR_W  next PC when branch_taken
- halt_req  in  1  stop after the current instruction
- resume  in  1  leave halted state
- phase  out  PH_W  current phase 1..PHASES; 0 when halted
- pc  out  ADDR_W  program counter
- pc_pre  out  ADDR_W  pc+1 latched at fetch
- ir  out  DATA_W  instruction register
- halted  out  1  sequencer halted
- cycle_count  out  CYC_W  clock cycles spent running (see Configuration)
- instr_count  out  CYC_W  retired instructions (see Configuration)

## Operation
- States: RUN(phase p), HALT.
- Reset values: phase=1, pc=0, pc_pre=0, ir=RESET_IR, halted=0, counters=0. Reset overrides every other input in the same cycle, mid-fetch included. Any imem_ack arriving in the reset cycle is discarded.
- Phase 1:
  - imem_req=1, imem_addr=pc; both are combinational.
  - While imem_ack=0, the phase holds and ir/pc_pre are unchanged.
  - On imem_ack=1: ir<=imem_rdata, pc_pre<=pc+1 (mod 2^ADDR_W; 16'hFFFF wraps to 0), phase<=2.
  - stall is ignored in phase 1.
- Phases 2..PHASES-1: advance by 1 per cycle when stall=0; hold when stall=1.
- Phase PHASES, when stall=0:
  - pc<=branch_taken ? branch_target : pc_pre.
  - instr_count+=1.
  - If halt_req=1: enter HALT (phase=0, halted=1). Otherwise phase<=1.
- halt_req outside phase PHASES has no effect; it is not latched.
- HALT: imem_req=0, and pc/ir/pc_pre hold. resume=1 gives phase<=1 and halted<=0 next cycle. resume outside HALT is ignored.
- PHASES=2: phase 2 is both the only execute phase and write-back.
- pc, pc_pre and ir change only at the points listed above.

## Timing
- Zero-wait fetch (imem_ack high in the first phase-1 cycle): one instruction per PHASES cycles. Phase 1 lasts 1 + (number of ack-low cycles).
- ir and pc_pre are visible from the first cycle of phase 2.
- New pc is visible in the first cycle of the next phase 1, so imem_addr reflects a branch target with no bubble.
- cycle_count increments in every non-reset cycle where halted=0, stall and wait cycles included. It wraps at 2^CYC_W.
- Entering HALT takes 1 cycle after phase PHASES. Resume takes 1 cycle.

## Configuration
- FETCH_SEQ_PERF_EN defined: cycle_count and instr_count are live registers as specified.
- Not defined: both outputs are tied to 0 and no counter flops are built. All other behaviour is identical.

## Structure
- Shared package fetch_pkg holds:
  - the default width constants (DATA_W, ADDR_W)
  - RESET_IR / halt opcode constant
  - run/halt state enum
- One sub-module, fetch_phase_ctr, is natural. It holds the phase counter plus HALT state, and takes ack/stall/halt_req/resume. PC/IR/counter registers stay in the top level.

## Test plan
- Reset, zero-wait ack, PHASES=5: imem_rdata=16'h1234 at pc=0 → ir=16'h1234, pc_pre=1 at phase 2; pc=1 at the next phase 1; 5 cycles per instruction.
- Ack delayed 3 cycles at pc=7: phase stays 1 for 4 cycles, ir is unchanged until ack, and cycle_count advances by 8 for that instruction.
- branch_taken=1, branch_target=16'h0040 in phase 5 → the next imem_addr is 16'h0040. pc=16'hFFFF without branch → pc_pre=0, next pc=0.
- stall=1 for 2 cycles in phase 3 → phase reads 3 for 3 cycles; pc is unchanged until phase 5.
- halt_req=1 in phase 5 → phase=0, halted=1, imem_req=0, pc held. resume → phase=1 next cycle and fetch continues at the held pc.
- Reset asserted while waiting for ack with ack in the same cycle → ir=RESET_IR, pc=0, phase=1. With FETCH_SEQ_PERF_EN undefined, both counters read 0 throughout.
